// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter that shares an 8:1 single-bit mux between eight requesters
//   clk   : system clock, rising edge
//   rst   : asynchronous active-high reset
//   req   : per-requester request, bit k = requester k
//   din   : mux data inputs, din[k] belongs to requester k
//   gnt   : one-hot grant, zero when idle
//   sel   : mux select, always the owner register
//   dout  : registered sample of din[sel]
//   valid : dout holds a fresh sample this cycle
//   busy  : a grant is active
module rr_mux_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] din,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       dout,
    output logic       valid,
    output logic       busy
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t     state_q;
    logic [2:0] ptr_q, owner_q, win;
    logic [7:0] cnt_q;
    logic       dout_q, valid_q;
    // Scan downward so the first requester in rotated order from ptr_q wins.
    always_comb begin
        win = ptr_q;
        for (int i = 7; i >= 0; i--)
            if (req[ptr_q + 3'(i)]) win = ptr_q + 3'(i);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (state_q == IDLE) begin
            valid_q <= 1'b0;
            if (|req) begin
                owner_q <= win;
                cnt_q   <= '0;
                state_q <= BUSY;
            end
        end else if (req[owner_q]) begin
            dout_q  <= din[owner_q];
            valid_q <= 1'b1;
            cnt_q   <= cnt_q + 8'd1;
            if (cnt_q == 8'(MAX_HOLD - 1)) begin
                state_q <= IDLE;
                ptr_q   <= owner_q + 3'd1;
            end
        end else begin
            // Early release: no sample, the owner still drops to lowest priority.
            valid_q <= 1'b0;
            state_q <= IDLE;
            ptr_q   <= owner_q + 3'd1;
        end
    end
    assign busy  = (state_q == BUSY);
    assign gnt   = busy ? (8'd1 << owner_q) : 8'd0;
    assign sel   = owner_q;
    assign dout  = dout_q;
    assign valid = valid_q;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: scoreboard bench for rr_mux_arbiter built with MAX_HOLD=4 and MAX_HOLD=1
module tb_rr_mux_arbiter;
    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       busy;
        logic       valid;
        logic       dout;
    } obs_t;
    logic       clk, rst;
    logic [7:0] req, din;
    logic [7:0] gnt0, gnt1;
    logic [2:0] sel0, sel1;
    logic       dout0, dout1, valid0, valid1, busy0, busy1;
    int         tests = 0, fails = 0;
    obs_t       q0[$], q1[$];
    int         own[2], last[2], nsmp[2];
    int         hold[2] = '{4, 1};
    logic [2:0] selm[2];
    logic       vm[2], dm[2];
    rr_mux_arbiter #(.MAX_HOLD(4)) dut0 (
        .clk(clk), .rst(rst), .req(req), .din(din), .gnt(gnt0), .sel(sel0),
        .dout(dout0), .valid(valid0), .busy(busy0));
    rr_mux_arbiter #(.MAX_HOLD(1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .din(din), .gnt(gnt1), .sel(sel1),
        .dout(dout1), .valid(valid1), .busy(busy1));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    function automatic void m_reset(int d);
        own[d] = -1; last[d] = 7; nsmp[d] = 0; selm[d] = '0; vm[d] = 1'b0; dm[d] = 1'b0;
    endfunction
    // Priority rotates so the last served requester comes last; a grant serves up to hold samples.
    function automatic void m_step(int d, logic [7:0] r, logic [7:0] x);
        if (own[d] < 0) begin
            bit found = 0;
            vm[d] = 1'b0;
            for (int j = 1; j <= 8; j++) begin
                int k = (last[d] + j) % 8;
                if (!found && r[k]) begin
                    found = 1; own[d] = k; selm[d] = 3'(k); nsmp[d] = 0;
                end
            end
        end else if (r[own[d]]) begin
            dm[d] = x[own[d]]; vm[d] = 1'b1; nsmp[d]++;
            if (nsmp[d] == hold[d]) begin last[d] = own[d]; own[d] = -1; end
        end else begin
            vm[d] = 1'b0; last[d] = own[d]; own[d] = -1;
        end
    endfunction
    function automatic obs_t m_obs(int d);
        obs_t o;
        o.gnt   = (own[d] >= 0) ? 8'(1 << own[d]) : 8'd0;
        o.sel   = selm[d];
        o.busy  = (own[d] >= 0);
        o.valid = vm[d];
        o.dout  = dm[d];
        return o;
    endfunction
    function automatic void check(string name, obs_t act, obs_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got gnt=%h sel=%0d busy=%b valid=%b dout=%b, want gnt=%h sel=%0d busy=%b valid=%b dout=%b",
                     name, $time, act.gnt, act.sel, act.busy, act.valid, act.dout,
                     exp.gnt, exp.sel, exp.busy, exp.valid, exp.dout);
        end
    endfunction
    task automatic drive(input logic r_st, input logic [7:0] r, input logic [7:0] x);
        @(negedge clk);
        rst = r_st; req = r; din = x;
        for (int d = 0; d < 2; d++) begin
            if (r_st) m_reset(d); else m_step(d, r, x);
        end
        q0.push_back(m_obs(0));
        q1.push_back(m_obs(1));
        if (r_st) begin
            #1;
            check("async_reset_h4", {gnt0, sel0, busy0, valid0, dout0}, '0);
            check("async_reset_h1", {gnt1, sel1, busy1, valid1, dout1}, '0);
        end
    endtask
    always @(posedge clk) begin
        #1;
        if (q0.size() > 0) check("cycle_h4", {gnt0, sel0, busy0, valid0, dout0}, q0.pop_front());
        if (q1.size() > 0) check("cycle_h1", {gnt1, sel1, busy1, valid1, dout1}, q1.pop_front());
    end
    initial begin
        rst = 1'b1; req = '0; din = '0;
        m_reset(0); m_reset(1);
        drive(1, 8'h00, 8'h00);
        drive(0, 8'h00, 8'h00);
        for (int i = 0; i < 12; i++) drive(0, 8'h04, (i % 2 == 1) ? 8'h04 : 8'h00);
        for (int i = 0; i < 3; i++) drive(0, 8'h00, 8'hFF);
        for (int i = 0; i < 3; i++) drive(0, 8'h20, 8'hFF);
        drive(1, 8'h20, 8'hFF);
        for (int i = 0; i < 3; i++) drive(0, 8'h00, 8'hFF);
        for (int i = 0; i < 45; i++) drive(0, 8'hFF, 8'($urandom));
        drive(1, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) drive(0, 8'h08, 8'h08);
        drive(0, 8'h00, 8'h08);
        for (int i = 0; i < 12; i++) drive(0, 8'h18, 8'($urandom));
        drive(1, 8'h00, 8'h00);
        for (int i = 0; i < 5; i++) drive(0, 8'h40, 8'h40);
        for (int i = 0; i < 14; i++) drive(0, 8'h81, 8'($urandom));
        drive(1, 8'h00, 8'h00);
        for (int i = 0; i < 10; i++) drive(0, 8'h03, 8'($urandom));
        begin
            logic [7:0] r = '0;
            for (int i = 0; i < 800; i++) begin
                if ($urandom_range(0, 3) == 0) r = 8'($urandom) & 8'($urandom);
                drive($urandom_range(0, 99) == 0, r, 8'($urandom));
            end
        end
        @(negedge clk);
        @(posedge clk);
        #2;
        tests++;
        if (q0.size() + q1.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", q0.size() + q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
